// File: rtl/md_stall_ctrl.sv
// Multiply/divide busy sequencer and pipeline stall merge.
// A down-counter tracks the in-flight mult/div latency; its busy state is
// combined with the external data-hazard request to hold F/D and bubble D/E.
module md_stall_ctrl #(
  parameter int MULT_CYCLES = 5,
  parameter int DIV_CYCLES  = 10,
  parameter int CNT_W       = 4
) (
  input  logic clk,
  input  logic reset,
  input  logic E_md_start,
  input  logic E_md_is_div,
  input  logic md_abort,
  input  logic D_uses_md,
  input  logic D_data_stall,
  output logic md_busy,
  output logic md_done,
  output logic md_err,
  output logic stall,
  output logic pc_en,
  output logic fd_en,
  output logic de_clear
);

  localparam logic [CNT_W-1:0] MULT_LOAD = CNT_W'(MULT_CYCLES);
  localparam logic [CNT_W-1:0] DIV_LOAD  = CNT_W'(DIV_CYCLES);
  localparam logic [CNT_W-1:0] CNT_ONE   = CNT_W'(1);

  typedef enum logic {
    IDLE = 1'b0,
    BUSY = 1'b1
  } state_t;

  state_t           state;
  state_t           state_nxt;
  logic [CNT_W-1:0] cnt;
  logic [CNT_W-1:0] cnt_nxt;
  logic             done_nxt;
  logic             err_nxt;

  // State, counter and status flags; everything returns to idle on reset.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state   <= IDLE;
      cnt     <= '0;
      md_done <= 1'b0;
      md_err  <= 1'b0;
    end else begin
      state   <= state_nxt;
      cnt     <= cnt_nxt;
      md_done <= done_nxt;
      md_err  <= err_nxt;
    end
  end

  // Next-state: accept a start in IDLE, count down in BUSY; abort beats done.
  always_comb begin
    state_nxt = state;
    cnt_nxt   = cnt;
    done_nxt  = 1'b0;
    err_nxt   = md_err;
    case (state)
      IDLE: begin
        if (E_md_start && !md_abort) begin
          state_nxt = BUSY;
          cnt_nxt   = E_md_is_div ? DIV_LOAD : MULT_LOAD;
        end
      end
      BUSY: begin
        // A start while busy is dropped (no reload) but latched as an error.
        if (E_md_start) begin
          err_nxt = 1'b1;
        end
        if (md_abort) begin
          state_nxt = IDLE;
          cnt_nxt   = '0;
        end else if (cnt == CNT_ONE) begin
          state_nxt = IDLE;
          cnt_nxt   = '0;
          done_nxt  = 1'b1;
        end else begin
          cnt_nxt = cnt - CNT_ONE;
        end
      end
      default: begin
        state_nxt = IDLE;
        cnt_nxt   = '0;
      end
    endcase
  end

  // Stall merge; the pipeline is frozen with a bubble in E while reset is held.
  always_comb begin
    md_busy  = (state == BUSY);
    stall    = D_data_stall | (D_uses_md & (E_md_start | md_busy));
    pc_en    = reset & ~stall;
    fd_en    = reset & ~stall;
    de_clear = ~reset | stall;
  end

endmodule
